// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC integrate-and-dump accumulator: data widths,
// DDC word field offsets, the per-channel accumulator pair type and the
// sign-extension helper used on incoming samples.
package ddc_pkg;

  localparam int IN_RES     = 27;
  localparam int ACC_RES    = 48;
  localparam int OUT_RES    = 32;
  localparam int MAX_LEN_W  = 16;
  localparam int FIFO_DEPTH = 2;

  // Bit offsets of the I and Q components inside a 64-bit DDC word
  localparam int I_LSB = 0;
  localparam int Q_LSB = 32;

  typedef struct packed {
    logic signed [ACC_RES-1:0] i;
    logic signed [ACC_RES-1:0] q;
  } iq_acc_t;

  // Sign-extend one raw I/Q sample pair to accumulator width
  function automatic iq_acc_t sext_iq(input logic signed [IN_RES-1:0] i_raw,
                                      input logic signed [IN_RES-1:0] q_raw);
    iq_acc_t r;
    r.i = {{(ACC_RES-IN_RES){i_raw[IN_RES-1]}}, i_raw};
    r.q = {{(ACC_RES-IN_RES){q_raw[IN_RES-1]}}, q_raw};
    return r;
  endfunction

endpackage

// File: rtl/ddc_acc_fifo.sv
// Two-entry first-word fall-through FIFO for finished I/Q results.
// The head entry is always visible on rdata; a push into a full FIFO is only
// accepted when a pop happens in the same cycle. Storage is reset so the
// output word reads zero after reset.
module ddc_acc_fifo
  import ddc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop keeps count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem[k] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddc_accumulator.sv
// Integrate-and-dump decimator behind the DDC core. Sums len consecutive
// complex samples per channel, arithmetically shifts the sums and queues one
// 64-bit {Q, I} word per frame on an AXI4-Stream master.
// Optional build macro DDC_ACC_SAT_EN: saturate the shifted result to OUT_RES
// bits instead of wrapping.
module ddc_accumulator
  import ddc_pkg::*;
#(
  parameter int IN_RES    = ddc_pkg::IN_RES,
  parameter int ACC_RES   = ddc_pkg::ACC_RES,
  parameter int MAX_LEN_W = ddc_pkg::MAX_LEN_W,
  parameter int OUT_RES   = ddc_pkg::OUT_RES
) (
  input  logic                 s_axis_aclk,
  input  logic                 rst,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic [MAX_LEN_W-1:0] len,
  input  logic [4:0]           shift,
  input  logic                 resync,
  output logic [63:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overflow
);

  // Arithmetic right shift of an accumulated sum
  function automatic logic signed [ACC_RES-1:0] ashr(input logic signed [ACC_RES-1:0] v,
                                                      input logic [4:0] sh);
    return v >>> sh;
  endfunction

  // Reduce a shifted sum to output width (saturating or wrapping)
  function automatic logic signed [OUT_RES-1:0] fit_out(input logic signed [ACC_RES-1:0] v);
`ifdef DDC_ACC_SAT_EN
    logic signed [ACC_RES-1:0] hi;
    logic signed [ACC_RES-1:0] lo;
    hi = {{(ACC_RES-OUT_RES+1){1'b0}}, {(OUT_RES-1){1'b1}}};
    lo = ~hi;
    if (v > hi) begin
      return hi[OUT_RES-1:0];
    end else if (v < lo) begin
      return lo[OUT_RES-1:0];
    end else begin
      return v[OUT_RES-1:0];
    end
`else
    return v[OUT_RES-1:0];
`endif
  endfunction

  iq_acc_t                     smp;
  logic                        unused_pad;
  logic [MAX_LEN_W-1:0]        len_in;
  logic [MAX_LEN_W-1:0]        len_eff;
  logic [4:0]                  sh_eff;
  logic                        frame_start;
  logic                        last_smp;
  logic signed [ACC_RES-1:0]   sum_i;
  logic signed [ACC_RES-1:0]   sum_q;

  logic [MAX_LEN_W-1:0]        cnt_p0;
  logic [MAX_LEN_W-1:0]        len_l;
  logic [4:0]                  shift_l;
  logic signed [ACC_RES-1:0]   acc_i_p0;
  logic signed [ACC_RES-1:0]   acc_q_p0;
  logic signed [ACC_RES-1:0]   dump_i_p0;
  logic signed [ACC_RES-1:0]   dump_q_p0;
  logic [4:0]                  dump_sh_p0;
  logic                        vld_p0;

  logic signed [OUT_RES-1:0]   res_i_p1;
  logic signed [OUT_RES-1:0]   res_q_p1;
  logic                        vld_p1;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;

  // Sign padding bits of the DDC word carry no information
  assign unused_pad = ^{s_axis_tdata[63:59], s_axis_tdata[31:27]};

  // Frame bookkeeping: a frame that starts this cycle uses the live len/shift
  always_comb begin
    smp         = sext_iq(s_axis_tdata[I_LSB +: IN_RES], s_axis_tdata[Q_LSB +: IN_RES]);
    len_in      = (len == '0) ? MAX_LEN_W'(1) : len;
    frame_start = s_axis_tvalid && (cnt_p0 == '0);
    len_eff     = frame_start ? len_in : len_l;
    sh_eff      = frame_start ? shift : shift_l;
    last_smp    = (cnt_p0 == (len_eff - MAX_LEN_W'(1)));
    sum_i       = acc_i_p0 + ACC_RES'(smp.i);
    sum_q       = acc_q_p0 + ACC_RES'(smp.q);
  end

  // ---- stage p0: integrate, count and dump ----
  // Accumulator and sample counter; the last sample clears both so the next
  // frame can start on the following cycle
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
      cnt_p0   <= '0;
      len_l    <= MAX_LEN_W'(1);
      shift_l  <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (resync) begin
        acc_i_p0 <= '0;
        acc_q_p0 <= '0;
        cnt_p0   <= '0;
      end else if (s_axis_tvalid) begin
        if (frame_start) begin
          len_l   <= len_in;
          shift_l <= shift;
        end
        if (last_smp) begin
          acc_i_p0 <= '0;
          acc_q_p0 <= '0;
          cnt_p0   <= '0;
          vld_p0   <= 1'b1;
        end else begin
          acc_i_p0 <= sum_i;
          acc_q_p0 <= sum_q;
          cnt_p0   <= cnt_p0 + MAX_LEN_W'(1);
        end
      end
    end
  end

  // Dump register keeps the closed frame's sums and the shift that frame used
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_tvalid && !resync && last_smp) begin
      dump_i_p0  <= sum_i;
      dump_q_p0  <= sum_q;
      dump_sh_p0 <= sh_eff;
    end
  end

  // ---- stage p1: shift and reduce to output width ----
  // Result valid flag for the shift stage
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // Shifted and width-reduced result
  always_ff @(posedge s_axis_aclk) begin
    if (vld_p0) begin
      res_i_p1 <= fit_out(ashr(dump_i_p0, dump_sh_p0));
      res_q_p1 <= fit_out(ashr(dump_q_p0, dump_sh_p0));
    end
  end

  // ---- output FIFO ----
  assign fifo_pop      = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty;

  ddc_acc_fifo #(
    .WIDTH (2*OUT_RES)
  ) u_fifo (
    .clk   (s_axis_aclk),
    .rst   (rst),
    .push  (vld_p1),
    .wdata ({res_q_p1, res_i_p1}),
    .pop   (fifo_pop),
    .rdata (m_axis_tdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky flag: a result arrived while the FIFO was full and not draining
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (vld_p1 && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

endmodule
